// File: rtl/bios_program_loader_pkg.sv
// Shared constants and state encoding for the BIOS program loader.
package bios_program_loader_pkg;

    // Instruction word layout
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned ADDR_WIDTH   = 10;
    localparam int unsigned OPCODE_MSB   = 31;
    localparam int unsigned OPCODE_LSB   = 26;
    localparam int unsigned OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 6'b011101;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        LOAD    = 3'd2,
        HANDOFF = 3'd3,
        LOADED  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/bios_program_loader_if.sv
// Stream input and instruction-memory write port of the loader.
interface bios_program_loader_if #(
    parameter int unsigned DATA_WIDTH = bios_program_loader_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = bios_program_loader_pkg::ADDR_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    // Host side: supplies the stream, observes the memory writes
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_data
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_wr_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/bios_program_loader.sv
// Accepts a length-prefixed program stream, writes it into instruction
// memory, then pulses the core reset to hand execution over.
module bios_program_loader #(
    parameter int unsigned DATA_WIDTH  = bios_program_loader_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = bios_program_loader_pkg::ADDR_WIDTH,
    parameter int unsigned BASE_ADDR   = 0,
    parameter logic [5:0]  HALT_OPCODE = bios_program_loader_pkg::HALT_OPCODE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    bios_program_loader_if.slave  bus,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  loaded,
    output logic                  overflow_err
);
    import bios_program_loader_pkg::*;

    localparam int unsigned REM_WIDTH = ADDR_WIDTH + 1;
    localparam logic [63:0] CAPACITY  = 64'(1) << ADDR_WIDTH;

    loader_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [REM_WIDTH-1:0]   rem_q, rem_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   ovf_q, ovf_d;
    logic                   cpu_rst_q, busy_q, loaded_q;

    logic                   in_ready_c;
    logic                   xfer_c;
    logic                   halt_c;

    // Stream is accepted only while waiting for the header or program words
    assign in_ready_c = (state_q == HEADER) || (state_q == LOAD);
    assign xfer_c     = bus.in_valid && in_ready_c;
    assign halt_c     = bus.in_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;

    // Next-state, counters and write-stage inputs
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HEADER;
                    ovf_d   = 1'b0;
                end
            end
            HEADER: begin
                if (xfer_c) begin
                    if (bus.in_data == '0) begin
                        state_d = HANDOFF;
                    end else if (64'(bus.in_data) > CAPACITY) begin
                        state_d = IDLE;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                        rem_d   = REM_WIDTH'(bus.in_data);
                        addr_d  = ADDR_WIDTH'(BASE_ADDR);
                    end
                end
            end
            LOAD: begin
                if (xfer_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = bus.in_data;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    rem_d     = rem_q - REM_WIDTH'(1);
                    if ((rem_q == REM_WIDTH'(1)) || halt_c) begin
                        state_d = HANDOFF;
                    end
                end
            end
            HANDOFF: begin
                state_d = LOADED;
            end
            LOADED: begin
                if (start) begin
                    state_d = HEADER;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
            cpu_rst_q <= (state_d == HANDOFF);
            busy_q    <= (state_d == HEADER) || (state_d == LOAD) || (state_d == HANDOFF);
            loaded_q  <= (state_d == LOADED);
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign cpu_rst         = cpu_rst_q;
    assign busy            = busy_q;
    assign loaded          = loaded_q;
    assign overflow_err    = ovf_q;

endmodule

// File: tb/tb_bios_program_loader.sv
// Scoreboard bench for the BIOS program loader.
module tb_bios_program_loader;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    logic start;
    logic cpu_rst;
    logic busy;
    logic loaded;
    logic overflow_err;

    bios_program_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

    bios_program_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .BASE_ADDR  (0),
        .HALT_OPCODE(6'b011101)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus.slave),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .loaded      (loaded),
        .overflow_err(overflow_err)
    );

    int   errors = 0;
    int   checks = 0;
    int   rst_pulses = 0;
    logic [9:0] exp_addr = '0;
    wr_t  exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and score any memory write against the queue
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.mem_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%08h", bus.mem_addr, bus.mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write_content got addr=%0h data=%08h want addr=%0h data=%08h",
                             bus.mem_addr, bus.mem_wr_data, e.addr, e.data);
                end
            end
        end
        if (cpu_rst === 1'b1) rst_pulses++;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] len);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL header_ready got=%b want=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = len;
        step();
    endtask

    task automatic send_data(input logic [31:0] w);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL data_ready got=%b want=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        exp_q.push_back(wr_t'{exp_addr, w});
        exp_addr = exp_addr + 10'd1;
        step();
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic check_done(input string name, input int want_pulses);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_writes got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (rst_pulses != want_pulses) begin
            errors++;
            $display("FAIL %s_cpu_rst_pulses got=%0d want=%0d", name, rst_pulses, want_pulses);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_bit("reset_wr_en", bus.mem_wr_en, 1'b0);
        check_bit("reset_cpu_rst", cpu_rst, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_loaded", loaded, 1'b0);
        check_bit("reset_overflow", overflow_err, 1'b0);
        check_bit("reset_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        step();
        check_bit("idle_busy", busy, 1'b0);
    endtask

    task automatic test_normal_load();
        rst_pulses = 0;
        exp_addr   = 10'd0;
        do_start();
        check_bit("normal_busy", busy, 1'b1);
        send_header(32'd3);
        send_data(32'h1111_1111);
        send_data(32'h2222_2222);
        send_data(32'h3333_3333);
        check_bit("normal_cpu_rst_with_last_write", cpu_rst, 1'b1);
        check_bit("normal_last_write_en", bus.mem_wr_en, 1'b1);
        check_bit("normal_handoff_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        step();
        check_bit("normal_cpu_rst_low", cpu_rst, 1'b0);
        check_bit("normal_loaded", loaded, 1'b1);
        check_bit("normal_busy_low", busy, 1'b0);
        check_done("normal", 1);
    endtask

    task automatic test_early_halt();
        rst_pulses = 0;
        exp_addr   = 10'd0;
        do_start();
        check_bit("halt_loaded_cleared", loaded, 1'b0);
        send_header(32'd5);
        send_data(32'h0000_0001);
        send_data(32'h7400_0000);
        check_bit("halt_ready_drop", bus.in_ready, 1'b0);
        check_bit("halt_cpu_rst", cpu_rst, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3333_3333;
        step();
        step();
        check_bit("halt_loaded", loaded, 1'b1);
        check_bit("halt_ready_after", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        step();
        check_done("halt", 1);
    endtask

    task automatic test_zero_length();
        rst_pulses = 0;
        do_start();
        send_header(32'd0);
        bus.in_valid = 1'b0;
        check_bit("zero_cpu_rst", cpu_rst, 1'b1);
        check_bit("zero_busy", busy, 1'b1);
        step();
        check_bit("zero_loaded", loaded, 1'b1);
        check_bit("zero_cpu_rst_low", cpu_rst, 1'b0);
        check_done("zero", 1);
    endtask

    task automatic test_overflow();
        rst_pulses = 0;
        do_start();
        send_header(32'd1025);
        bus.in_valid = 1'b0;
        check_bit("ovf_flag", overflow_err, 1'b1);
        check_bit("ovf_busy", busy, 1'b0);
        check_bit("ovf_loaded", loaded, 1'b0);
        check_bit("ovf_ready", bus.in_ready, 1'b0);
        step();
        check_bit("ovf_sticky", overflow_err, 1'b1);
        check_done("ovf", 0);
        do_start();
        check_bit("ovf_cleared", overflow_err, 1'b0);
        check_bit("ovf_restart_busy", busy, 1'b1);
        send_header(32'd1024);
        bus.in_valid = 1'b0;
        check_bit("ovf_capacity_ok", overflow_err, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_bubbles_and_stray();
        rst_pulses = 0;
        exp_addr   = 10'd0;
        do_start();
        send_header(32'd3);
        send_data(32'hA5A5_0001);
        bus.in_valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check_bit("bubble_still_loading", bus.in_ready, 1'b1);
        check_bit("bubble_busy", busy, 1'b1);
        send_data(32'hA5A5_0002);
        send_data(32'hA5A5_0003);
        bus.in_valid = 1'b0;
        step();
        check_bit("bubble_loaded", loaded, 1'b1);
        check_done("bubble", 1);
    endtask

    task automatic test_reset_mid_load();
        rst_pulses = 0;
        exp_addr   = 10'd0;
        do_start();
        send_header(32'd4);
        send_data(32'hC0DE_0000);
        send_data(32'hC0DE_0001);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hC0DE_0002;
        rst = 1'b1;
        step();
        check_bit("midrst_wr_en", bus.mem_wr_en, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_cpu_rst", cpu_rst, 1'b0);
        check_bit("midrst_loaded", loaded, 1'b0);
        check_bit("midrst_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        check_done("midrst", 0);
        exp_addr = 10'd0;
        do_start();
        send_header(32'd2);
        send_data(32'hBEEF_0000);
        send_data(32'hBEEF_0001);
        check_bit("reload_cpu_rst", cpu_rst, 1'b1);
        bus.in_valid = 1'b0;
        step();
        check_bit("reload_loaded", loaded, 1'b1);
        check_done("reload", 1);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_normal_load();
        test_early_halt();
        test_zero_length();
        test_overflow();
        test_bubbles_and_stray();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
